button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
Consumes the clean level produced by the input debouncer and turns it into one-cycle user-interface events: press, release, single click, double click and long press. Sits between the debouncer output and the control logic or CSRs that react to buttons. Each physical button gets one instance, cascaded directly after its debouncer instance.

Parameters:
LONG_CYCLES, 50_000_000, consecutive high samples (press edge counts as 1) needed to declare a long press; must be >= 2
GAP_CYCLES, 12_500_000, consecutive low samples after a short press release that end the double-click window; must be >= 2
CNT_W, $clog2(max(LONG_CYCLES,GAP_CYCLES)+1), counter width; derived, not overridden

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
in  input  1  debounced button level, synchronous to clk_i (already synchronised, no extra sync stages here)
press_o  output  1  one-cycle pulse on every 0->1 transition of in
release_o  output  1  one-cycle pulse on every 1->0 transition of in
click_o  output  1  one-cycle pulse: short press not followed by a second press within the gap
dbl_click_o  output  1  one-cycle pulse: second short press released inside the gap
long_o  output  1  one-cycle pulse: in held for LONG_CYCLES samples
state_o  output  3  current FSM state, for debug/CSR readback

Behaviour:
- Reset (rst_n_i low, asynchronous): all pulse outputs 0, in_q 0, counter 0, state IDLE, state_o = IDLE encoding. All outputs are registered; no combinational path from in to any output.
- Edge detect: in_q <= in every edge; rise = in & ~in_q, fall = ~in & in_q.
- press_o <= rise and release_o <= fall, independent of FSM. Latency 1 edge: high for exactly the cycle after the sampling edge.
- in high at reset deassertion is seen as a rise (in_q = 0); press_o fires and the FSM starts a press normally.
- FSM states and encoding: IDLE = 0, PRESS1 = 1, WAIT_GAP = 2, PRESS2 = 3, LONG = 4.
- IDLE:
  - rise -> PRESS1, counter <= 1.
- PRESS1:
  - in = 1: counter++.
  - At the edge where in is sampled 1 and counter == LONG_CYCLES-1: long_o <= 1, go to LONG.
  - fall -> WAIT_GAP, counter <= 1.
- WAIT_GAP:
  - in = 0: counter++.
  - At the edge where in is sampled 0 and counter == GAP_CYCLES-1: click_o <= 1, go to IDLE.
  - rise before that -> PRESS2, counter <= 1.
- PRESS2:
  - Counts as PRESS1 does.
  - fall before long -> dbl_click_o <= 1, go to IDLE.
  - Reaching LONG_CYCLES -> long_o <= 1, go to LONG; no dbl_click_o and no click_o for this sequence.
- LONG:
  - fall -> IDLE. No further event besides release_o.
  - long_o fires once per hold, never repeats.
- Boundaries:
  - Exactly GAP_CYCLES low samples ends the window: click_o fires. A rise on the next sample starts a fresh PRESS1.
  - Exactly LONG_CYCLES high samples is long.
  - At most one of click_o / dbl_click_o / long_o is high in any cycle.
  - press_o / release_o may coincide with dbl_click_o (release edge) or click_o never (click only while in low with no edge).
- Counter never wraps: every state leaves before counter reaches its limit; counter is unused in IDLE/LONG and held at 0 there.
- in toggling every cycle is handled per sample without lost edges: each rise/fall yields its pulse.

Decomposition:
- Shared package button_pkg holds the state encoding localparams (ST_IDLE..ST_LONG, width 3) and the state_o width.
- Default timing constants are named per 50 MHz board clock in the same package.
- No sub-module; edge detect and counter stay inline.
- The top-level pairing debouncer + button_event_decoder is wrapped in button_if at board level.

Test Plan:
All scenarios use LONG_CYCLES=8, GAP_CYCLES=4.
1. rst_n_i low for 3 cycles with in toggling, then release with in=0 -> all outputs 0, state_o=0 throughout reset and after.
2. in high for 3 samples, then low for 6 -> press_o at edge 1, release_o at edge 4, click_o at the 4th low sample (edge 7), nothing else.
3. in high for 10 samples, then low -> long_o at the 8th high sample only, release_o on fall, no click_o/dbl_click_o, state returns to 0.
4. high 2, low 2, high 2, low 6 -> two press_o, dbl_click_o on the second release edge together with release_o, no click_o.
5. high 2, low exactly 4, high 2, low 6 -> click_o at the 4th low sample, second press treated as a new PRESS1, second click_o 4 samples after its release.
6. rst_n_i asserted mid PRESS1 (counter=5) while in stays high, then released -> outputs clear immediately (async), press_o on first post-reset edge, long_o 8 samples later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button event decoder: FSM encoding and default
// timing constants for the 50 MHz board clock.
package button_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS1   = 3'd1,
    ST_WAIT_GAP = 3'd2,
    ST_PRESS2   = 3'd3,
    ST_LONG     = 3'd4
  } state_e;

  // 50 MHz board clock: 1 s long press, 250 ms double-click window.
  localparam int CLK_HZ              = 50_000_000;
  localparam int LONG_CYCLES_DEFAULT = CLK_HZ;
  localparam int GAP_CYCLES_DEFAULT  = CLK_HZ / 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/
// double-click/long-press events. All outputs are registered.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in,
  output logic               press_o,
  output logic               release_o,
  output logic               click_o,
  output logic               dbl_click_o,
  output logic               long_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             in_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_reg;
  state_e           state_reg;

  assign rise    = in & ~in_q;
  assign fall    = ~in & in_q;
  assign state_o = state_reg;

  // The counter holds the number of samples already seen in the current
  // press/gap phase, so the limit test uses LIMIT-1 on the deciding sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_q        <= 1'b0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
      click_o     <= 1'b0;
      dbl_click_o <= 1'b0;
      long_o      <= 1'b0;
      cnt_reg     <= '0;
      state_reg   <= ST_IDLE;
    end else begin
      in_q        <= in;
      press_o     <= rise;
      release_o   <= fall;
      click_o     <= 1'b0;
      dbl_click_o <= 1'b0;
      long_o      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (rise) begin
            state_reg <= ST_PRESS1;
            cnt_reg   <= CNT_ONE;
          end
        end

        ST_PRESS1, ST_PRESS2: begin
          if (fall) begin
            if (state_reg == ST_PRESS1) begin
              state_reg <= ST_WAIT_GAP;
              cnt_reg   <= CNT_ONE;
            end else begin
              dbl_click_o <= 1'b1;
              state_reg   <= ST_IDLE;
              cnt_reg     <= '0;
            end
          end else if (cnt_reg == LONG_LAST) begin
            long_o    <= 1'b1;
            state_reg <= ST_LONG;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_WAIT_GAP: begin
          if (rise) begin
            state_reg <= ST_PRESS2;
            cnt_reg   <= CNT_ONE;
          end else if (cnt_reg == GAP_LAST) begin
            click_o   <= 1'b1;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_LONG: begin
          cnt_reg <= '0;
          if (fall) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
